// File: rtl/fsm_transition_checker.sv
// Monitors a watched FSM state bus: checks every state change against a legal-transition
// table, flags out-of-range encodings and over-long dwell, and records error status.
module fsm_transition_checker #(
    parameter int unsigned STATE_W    = 4,
    parameter int unsigned NUM_STATES = 16,
    parameter logic [NUM_STATES*NUM_STATES-1:0] LEGAL_MAP = '1,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned HOLD_MAX   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [STATE_W-1:0] state_in,
    output logic               err_pulse,
    output logic               err_sticky,
    output logic               range_err,
    output logic               stuck_err,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   trans_count,
    output logic               first_valid,
    output logic [STATE_W-1:0] first_from,
    output logic [STATE_W-1:0] first_to,
    output logic [STATE_W-1:0] last_state
);

    localparam int unsigned MAP_W   = NUM_STATES * NUM_STATES;
    localparam int unsigned IDX_W   = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int unsigned DWELL_W = $clog2(HOLD_MAX + 2);
    localparam logic [DWELL_W-1:0] DWELL_MAX  = DWELL_W'(HOLD_MAX + 1);
    localparam logic [DWELL_W-1:0] DWELL_HOLD = DWELL_W'(HOLD_MAX);

    logic               prev_valid_q, prev_valid_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               err_pulse_d, err_sticky_d, range_err_d, stuck_err_d, first_valid_d;
    logic [CNT_W-1:0]   err_count_d, trans_count_d;
    logic [STATE_W-1:0] first_from_d, first_to_d, last_state_d;

    logic        check;
    logic        s_oor, p_oor, same, legal;
    logic        range_hit, illegal_hit, stuck_hit, legal_hit, any_err;
    logic [31:0] map_idx;

    assign check   = en && prev_valid_q;
    assign s_oor   = 32'(state_in) >= NUM_STATES;
    assign p_oor   = 32'(last_state) >= NUM_STATES;
    assign same    = state_in == last_state;
    assign map_idx = 32'(state_in) * NUM_STATES + 32'(last_state);
    // An out-of-range from-state has no table row, so any change out of it is illegal.
    assign legal   = !s_oor && !p_oor && LEGAL_MAP[map_idx[IDX_W-1:0]];

    assign range_hit   = check && s_oor;
    assign illegal_hit = check && !s_oor && !same && !legal;
    assign legal_hit   = check && !s_oor && !same && legal;
    assign stuck_hit   = check && (HOLD_MAX != 0) && same && (dwell_q == DWELL_HOLD);
    assign any_err     = range_hit || illegal_hit || stuck_hit;

    always_comb begin
        prev_valid_d  = prev_valid_q;
        dwell_d       = dwell_q;
        err_pulse_d   = 1'b0;
        err_sticky_d  = err_sticky;
        range_err_d   = range_err;
        stuck_err_d   = stuck_err;
        err_count_d   = err_count;
        trans_count_d = trans_count;
        first_valid_d = first_valid;
        first_from_d  = first_from;
        first_to_d    = first_to;
        last_state_d  = last_state;

        // Clear first, so an error in the same cycle is recorded on top of it.
        if (clr) begin
            err_sticky_d  = 1'b0;
            range_err_d   = 1'b0;
            stuck_err_d   = 1'b0;
            err_count_d   = '0;
            first_valid_d = 1'b0;
            first_from_d  = '0;
            first_to_d    = '0;
        end

        if (!en) begin
            prev_valid_d = 1'b0;
            dwell_d      = '0;
        end else begin
            last_state_d = state_in;
            prev_valid_d = 1'b1;
            if (!prev_valid_q || !same) begin
                dwell_d = DWELL_W'(1);
            end else if (dwell_q != DWELL_MAX) begin
                dwell_d = dwell_q + DWELL_W'(1);
            end
        end

        if (legal_hit) begin
            trans_count_d = trans_count + CNT_W'(1);
        end
        if (range_hit) begin
            range_err_d = 1'b1;
        end
        if (stuck_hit) begin
            stuck_err_d = 1'b1;
        end
        if (any_err) begin
            err_pulse_d  = 1'b1;
            err_sticky_d = 1'b1;
            if (err_count_d != '1) begin
                err_count_d = err_count_d + CNT_W'(1);
            end
            if (!first_valid_d) begin
                first_valid_d = 1'b1;
                first_from_d  = last_state;
                first_to_d    = state_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_valid_q <= 1'b0;
            dwell_q      <= '0;
            err_pulse    <= 1'b0;
            err_sticky   <= 1'b0;
            range_err    <= 1'b0;
            stuck_err    <= 1'b0;
            err_count    <= '0;
            trans_count  <= '0;
            first_valid  <= 1'b0;
            first_from   <= '0;
            first_to     <= '0;
            last_state   <= '0;
        end else begin
            prev_valid_q <= prev_valid_d;
            dwell_q      <= dwell_d;
            err_pulse    <= err_pulse_d;
            err_sticky   <= err_sticky_d;
            range_err    <= range_err_d;
            stuck_err    <= stuck_err_d;
            err_count    <= err_count_d;
            trans_count  <= trans_count_d;
            first_valid  <= first_valid_d;
            first_from   <= first_from_d;
            first_to     <= first_to_d;
            last_state   <= last_state_d;
        end
    end

endmodule

// File: tb/tb_fsm_transition_checker.sv
// Two checker instances (16 states/no hold limit, 6 states/HOLD_MAX=3/3-bit counters) share
// stimulus; a reference model pushes expected outputs that a negedge monitor pops and compares.
module tb_fsm_transition_checker;

    // Entries into state 1 are legal only from 0, 3 and 5; everything else is legal.
    function automatic logic [255:0] build_map(input int n);
        logic [255:0] m;
        m = '0;
        for (int t = 0; t < n; t++) begin
            for (int f = 0; f < n; f++) begin
                m[t*n+f] = (t != 1) || (f == 0) || (f == 3) || (f == 5);
            end
        end
        return m;
    endfunction

    localparam logic [255:0] MAP_A = build_map(16);
    localparam logic [255:0] MAP_B = build_map(6);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] state_in = '0;

    logic       a_pulse, a_sticky, a_range, a_stuck, a_fv;
    logic [7:0] a_ecnt, a_tcnt;
    logic [3:0] a_ff, a_ft, a_last;
    logic       b_pulse, b_sticky, b_range, b_stuck, b_fv;
    logic [2:0] b_ecnt, b_tcnt;
    logic [3:0] b_ff, b_ft, b_last;

    fsm_transition_checker #(
        .STATE_W(4), .NUM_STATES(16), .LEGAL_MAP(MAP_A), .CNT_W(8), .HOLD_MAX(0)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .state_in(state_in),
        .err_pulse(a_pulse), .err_sticky(a_sticky), .range_err(a_range), .stuck_err(a_stuck),
        .err_count(a_ecnt), .trans_count(a_tcnt), .first_valid(a_fv), .first_from(a_ff),
        .first_to(a_ft), .last_state(a_last)
    );

    fsm_transition_checker #(
        .STATE_W(4), .NUM_STATES(6), .LEGAL_MAP(MAP_B[35:0]), .CNT_W(3), .HOLD_MAX(3)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .state_in(state_in),
        .err_pulse(b_pulse), .err_sticky(b_sticky), .range_err(b_range), .stuck_err(b_stuck),
        .err_count(b_ecnt), .trans_count(b_tcnt), .first_valid(b_fv), .first_from(b_ff),
        .first_to(b_ft), .last_state(b_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit pv; int last; int dwell;
        bit pulse; bit sticky; bit rng; bit stuck; bit fv;
        int ecnt; int tcnt; int ff; int ft;
    } mdl_t;

    mdl_t m [2];
    mdl_t qa [$];
    mdl_t qb [$];
    int   nst  [2] = '{16, 6};
    int   hold [2] = '{0, 3};
    int   cmax [2] = '{255, 7};
    int   total = 0;
    int   bad = 0;
    int   drv = 0;

    function automatic bit is_legal(input int from, input int to, input int n);
        if (from >= n || to >= n) return 1'b0;
        return (to != 1) || (from == 0) || (from == 3) || (from == 5);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mreset(input int k);
        m[k] = '{default: 0};
    endtask

    task automatic mstep(input int k, input bit e, input bit c, input int s);
        bit err;
        m[k].pulse = 1'b0;
        if (c) begin
            m[k].sticky = 0; m[k].rng = 0; m[k].stuck = 0;
            m[k].ecnt = 0; m[k].fv = 0; m[k].ff = 0; m[k].ft = 0;
        end
        if (!e) begin
            m[k].pv = 0;
            m[k].dwell = 0;
        end else if (!m[k].pv) begin
            m[k].pv = 1; m[k].last = s; m[k].dwell = 1;
        end else begin
            err = 0;
            if (s == m[k].last) begin
                if (hold[k] > 0 && m[k].dwell == hold[k]) begin
                    err = 1; m[k].stuck = 1;
                end
                if (m[k].dwell < hold[k] + 1) m[k].dwell++;
            end else begin
                m[k].dwell = 1;
            end
            if (s >= nst[k]) begin
                err = 1; m[k].rng = 1;
            end else if (s != m[k].last) begin
                if (is_legal(m[k].last, s, nst[k])) m[k].tcnt = (m[k].tcnt + 1) % (cmax[k] + 1);
                else err = 1;
            end
            if (err) begin
                m[k].pulse = 1; m[k].sticky = 1;
                if (m[k].ecnt < cmax[k]) m[k].ecnt++;
                if (!m[k].fv) begin
                    m[k].fv = 1; m[k].ff = m[k].last; m[k].ft = s;
                end
            end
            m[k].last = s;
        end
    endtask

    function automatic mdl_t get_dut(input int k);
        mdl_t d;
        d = '{default: 0};
        if (k == 0) begin
            d.pulse = a_pulse; d.sticky = a_sticky; d.rng = a_range; d.stuck = a_stuck;
            d.ecnt = int'(a_ecnt); d.tcnt = int'(a_tcnt); d.fv = a_fv;
            d.ff = int'(a_ff); d.ft = int'(a_ft); d.last = int'(a_last);
        end else begin
            d.pulse = b_pulse; d.sticky = b_sticky; d.rng = b_range; d.stuck = b_stuck;
            d.ecnt = int'(b_ecnt); d.tcnt = int'(b_tcnt); d.fv = b_fv;
            d.ff = int'(b_ff); d.ft = int'(b_ft); d.last = int'(b_last);
        end
        return d;
    endfunction

    task automatic compare(input string p, input mdl_t a, input mdl_t e);
        check({p, ".err_pulse"}, int'(a.pulse), int'(e.pulse));
        check({p, ".err_sticky"}, int'(a.sticky), int'(e.sticky));
        check({p, ".range_err"}, int'(a.rng), int'(e.rng));
        check({p, ".stuck_err"}, int'(a.stuck), int'(e.stuck));
        check({p, ".err_count"}, a.ecnt, e.ecnt);
        check({p, ".trans_count"}, a.tcnt, e.tcnt);
        check({p, ".first_valid"}, int'(a.fv), int'(e.fv));
        check({p, ".first_from"}, a.ff, e.ff);
        check({p, ".first_to"}, a.ft, e.ft);
        check({p, ".last_state"}, a.last, e.last);
    endtask

    // Monitor: outputs are registered, so the negedge after each sampling posedge is stable.
    always @(negedge clk) begin
        if (qa.size() > 0) compare("a", get_dut(0), qa.pop_front());
        if (qb.size() > 0) compare("b", get_dut(1), qb.pop_front());
    end

    task automatic step(input bit rst, input bit e, input bit c, input int s);
        @(negedge clk);
        #1;
        rst_n = !rst;
        en = e;
        clr = c;
        drv = s;
        state_in = drv[3:0];
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) mreset(k);
            else mstep(k, e, c, s);
        end
        qa.push_back(m[0]);
        qb.push_back(m[1]);
    endtask

    task automatic seq(input int s);
        step(1'b0, 1'b1, 1'b0, s);
    endtask

    initial begin
        int s;
        int prev;
        mreset(0);
        mreset(1);

        step(1'b1, 1'b0, 1'b0, 0);
        #2;
        check("reset a.last_state", int'(a_last), 0);
        check("reset b.err_count", int'(b_ecnt), 0);

        seq(0); seq(1); seq(2); seq(3); seq(1);
        #2;
        check("legal_seq a.trans_count", int'(a_tcnt), 4);
        check("legal_seq a.err_count", int'(a_ecnt), 0);
        check("legal_seq a.last_state", int'(a_last), 1);

        seq(0); seq(2); seq(1);
        #2;
        check("illegal a.err_pulse", int'(a_pulse), 1);
        check("illegal a.err_count", int'(a_ecnt), 1);
        check("illegal a.first_from", int'(a_ff), 2);
        check("illegal a.first_to", int'(a_ft), 1);
        seq(4); seq(1);
        #2;
        check("second a.err_count", int'(a_ecnt), 2);
        check("second a.first_from", int'(a_ff), 2);
        step(1'b0, 1'b1, 1'b1, 1);
        #2;
        check("clr a.err_sticky", int'(a_sticky), 0);
        check("clr a.err_count", int'(a_ecnt), 0);
        check("clr a.first_valid", int'(a_fv), 0);
        check("clr a.last_state", int'(a_last), 1);

        step(1'b1, 1'b0, 1'b0, 0);
        seq(0); seq(7);
        #2;
        check("range b.range_err", int'(b_range), 1);
        check("range b.err_sticky", int'(b_sticky), 1);
        check("range b.err_count", int'(b_ecnt), 1);

        step(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) seq(2);
        #2;
        check("hold3 b.err_pulse", int'(b_pulse), 0);
        seq(2);
        #2;
        check("hold4 b.err_pulse", int'(b_pulse), 1);
        seq(2); seq(2);
        #2;
        check("hold b.stuck_err", int'(b_stuck), 1);
        check("hold b.err_count", int'(b_ecnt), 1);

        seq(2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1);
        seq(1);
        #2;
        check("reenable a.err_pulse", int'(a_pulse), 0);
        check("reenable a.err_count", int'(a_ecnt), 0);

        seq(4);
        step(1'b1, 1'b0, 1'b0, 4);
        seq(1);
        #2;
        check("post_reset a.err_pulse", int'(a_pulse), 0);
        check("post_reset a.last_state", int'(a_last), 1);

        prev = 0;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: s = prev;
                5:             s = $urandom_range(0, 15);
                default:       s = $urandom_range(0, 7);
            endcase
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 19) == 0, s);
            prev = s;
        end

        for (int i = 0; i < 10 && (qa.size() + qb.size()) > 0; i++) @(negedge clk);
        @(posedge clk);
        check("drain", qa.size() + qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
